// File: rtl/bus_pkg.sv
// Shared bus source indices and default bus-encoder sizing.
// Used by the select encoder and by anything that drives the bus mux.
package bus_pkg;

  localparam int N_SRC_DEF  = 24;
  localparam int CODE_W_DEF = 5;

  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_CONST  = 23;

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational priority pick starting at ptr_i, wrapping upward; no state.
// Latency 0; no backpressure (pure function of req_i and ptr_i).
module rr_prio_pick #(
  parameter int N = 24,
  parameter int W = 5
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  localparam int IW = $clog2(2 * N);

  logic [2*N-1:0] dbl;
  logic [IW-1:0]  hit;

  // Requests below the pointer are masked in the low copy, so the first hit
  // is either at/above ptr_i, or the wrapped copy of a lower request.
  always_comb begin
    dbl = {req_i, req_i} & ({(2 * N){1'b1}} << ptr_i);
    hit = '0;
    for (int i = 2 * N - 1; i >= 0; i--) begin
      if (dbl[i]) hit = IW'(i);
    end
    if (hit >= IW'(N)) idx_o = W'(hit - IW'(N));
    else               idx_o = W'(hit);
  end

  assign any_o = |req_i;

endmodule

// File: rtl/bus_src_encoder.sv
// Registered bus source-select encoder with conflict flag/counter; 1-cycle latency,
// no backpressure (en gates sampling). BUS_SRC_ENC_RR_EN selects round-robin grant.
module bus_src_encoder
  import bus_pkg::*;
#(
  parameter int N_SRC  = N_SRC_DEF,
  parameter int CODE_W = CODE_W_DEF,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [N_SRC-1:0]  req,
  input  logic              clr_cnt,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              conflict,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic [CODE_W-1:0] code_q, code_d;
  logic              valid_q, valid_d;
  logic              conf_q, conf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [CODE_W-1:0] ptr;
  logic [CODE_W-1:0] grant;
  logic              any;
  logic              multi;

  rr_prio_pick #(
    .N (N_SRC),
    .W (CODE_W)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr),
    .idx_o (grant),
    .any_o (any)
  );

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(req & (req - N_SRC'(1)));

`ifdef BUS_SRC_ENC_RR_EN
  logic [CODE_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en && any) begin
      ptr_d = (grant == CODE_W'(N_SRC - 1)) ? '0 : grant + CODE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    conf_d  = conf_q;
    cnt_d   = cnt_q;
    if (en) begin
      valid_d = any;
      conf_d  = multi;
      if (any) code_d = grant;
      if (multi && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end
    if (clr_cnt) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q  <= '0;
      valid_q <= 1'b0;
      conf_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
      conf_q  <= conf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign code         = code_q;
  assign valid        = valid_q;
  assign conflict     = conf_q;
  assign conflict_cnt = cnt_q;

endmodule
